// File: rtl/conf_loader.sv
// Serial configuration loader: shifts a captured word LSB-first into a chip config chain, then strobes load.
// Optional readback of the previous chain contents is compiled in with `define CONF_READBACK_EN.
module conf_loader #(
    parameter int CONF_WIDTH = 64,
    parameter int CLK_DIV    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [CONF_WIDTH-1:0] CONF_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  DEF_CONF,
    output logic                  CLK_CONF,
    output logic                  LD_CONF,
    output logic                  SI_CONF,
    input  logic                  SO_CONF,
    output logic [CONF_WIDTH-1:0] READBACK,
    output logic                  MISMATCH
);

    localparam int PER = 2 * CLK_DIV;
    localparam int PW  = $clog2(PER);
    localparam int BW  = $clog2(CONF_WIDTH + 1);

    localparam logic [PW-1:0] PER_LAST = PW'(PER - 1);
    localparam logic [PW-1:0] HALF     = PW'(CLK_DIV);
    localparam logic [PW-1:0] RISE_PRE = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CONF_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        GAP   = 3'd2,
        LOAD  = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t                  state_reg, state_next;
    logic [PW-1:0]           pcnt_reg, pcnt_next;
    logic [BW-1:0]           bcnt_reg, bcnt_next;
    logic [CONF_WIDTH-1:0]   shadow_reg, shadow_next;
    logic                    period_end;

    logic busy_reg, done_reg, def_reg, clk_conf_reg, ld_reg, si_reg;

    // The shadow word rotates once per bit period so bit 0 always holds the
    // bit being shifted; after CONF_WIDTH rotations it is the original word.
    always_comb begin
        state_next  = state_reg;
        pcnt_next   = pcnt_reg;
        bcnt_next   = bcnt_reg;
        shadow_next = shadow_reg;
        period_end  = (pcnt_reg == PER_LAST);
        case (state_reg)
            IDLE: begin
                if (START) begin
                    state_next  = SHIFT;
                    pcnt_next   = '0;
                    bcnt_next   = '0;
                    shadow_next = CONF_DATA;
                end
            end
            SHIFT: begin
                pcnt_next = period_end ? '0 : pcnt_reg + 1'b1;
                if (period_end) begin
                    shadow_next = {shadow_reg[0], shadow_reg[CONF_WIDTH-1:1]};
                    if (bcnt_reg == BIT_LAST) begin
                        state_next = GAP;
                    end else begin
                        bcnt_next = bcnt_reg + 1'b1;
                    end
                end
            end
            GAP: begin
                pcnt_next = period_end ? '0 : pcnt_reg + 1'b1;
                if (period_end) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                pcnt_next = period_end ? '0 : pcnt_reg + 1'b1;
                if (period_end) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
                pcnt_next  = '0;
            end
            default: begin
                state_next = IDLE;
                pcnt_next  = '0;
            end
        endcase
    end

    // Pad outputs are decoded from the next state so they are registered yet
    // aligned with the state they belong to.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            pcnt_reg     <= '0;
            bcnt_reg     <= '0;
            shadow_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            def_reg      <= 1'b1;
            clk_conf_reg <= 1'b0;
            ld_reg       <= 1'b0;
            si_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pcnt_reg     <= pcnt_next;
            bcnt_reg     <= bcnt_next;
            shadow_reg   <= shadow_next;
            busy_reg     <= (state_next != IDLE);
            done_reg     <= (state_next == FIN);
            clk_conf_reg <= ((state_next == SHIFT) || (state_next == GAP)) && (pcnt_next >= HALF);
            ld_reg       <= (state_next == LOAD);
            si_reg       <= (state_next == SHIFT) && shadow_next[0];
            if (state_next == FIN) begin
                def_reg <= 1'b0;
            end
        end
    end

    assign BUSY     = busy_reg;
    assign DONE     = done_reg;
    assign DEF_CONF = def_reg;
    assign CLK_CONF = clk_conf_reg;
    assign LD_CONF  = ld_reg;
    assign SI_CONF  = si_reg;

`ifdef CONF_READBACK_EN
    logic [CONF_WIDTH-1:0] rb_shift_reg;
    logic [CONF_WIDTH-1:0] readback_reg;
    logic [CONF_WIDTH-1:0] prev_word_reg;
    logic                  has_prev_reg;
    logic                  mismatch_reg;

    // SO_CONF is sampled on the edge that raises CLK_CONF, i.e. before the
    // chain itself advances on that rising edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rb_shift_reg  <= '0;
            readback_reg  <= '0;
            prev_word_reg <= '0;
            has_prev_reg  <= 1'b0;
            mismatch_reg  <= 1'b0;
        end else begin
            if ((state_reg == SHIFT) && (pcnt_reg == RISE_PRE)) begin
                rb_shift_reg <= {SO_CONF, rb_shift_reg[CONF_WIDTH-1:1]};
            end
            if (state_next == FIN) begin
                readback_reg  <= rb_shift_reg;
                mismatch_reg  <= has_prev_reg && (rb_shift_reg != prev_word_reg);
                prev_word_reg <= shadow_reg;
                has_prev_reg  <= 1'b1;
            end
        end
    end

    assign READBACK = readback_reg;
    assign MISMATCH = mismatch_reg;
`else
    logic so_unused;
    assign so_unused = SO_CONF;
    assign READBACK  = '0;
    assign MISMATCH  = 1'b0;
`endif

endmodule

// File: tb/tb_conf_loader.sv
// Bench for conf_loader: two instances (CLK_DIV=2 and CLK_DIV=1, CONF_WIDTH=8),
// a timeline model of the pad outputs checked every cycle, and directed loads.
module tb_conf_loader;

    logic       CLK;
    logic       RST;
    logic       corrupt;

    logic       start0, busy0, done0, def0, clkc0, ld0, si0, so0, mm0;
    logic [7:0] data0, rb0;
    logic       start1, busy1, done1, def1, clkc1, ld1, si1, so1, mm1;
    logic [7:0] data1, rb1;

    logic [7:0] chain0, chain1;
    int         cnt0, cnt1;
    logic [7:0] noise;

    int checks = 0;
    int errors = 0;

    conf_loader #(.CONF_WIDTH(8), .CLK_DIV(2)) dut0 (
        .CLK(CLK), .RST(RST), .START(start0), .CONF_DATA(data0),
        .BUSY(busy0), .DONE(done0), .DEF_CONF(def0), .CLK_CONF(clkc0),
        .LD_CONF(ld0), .SI_CONF(si0), .SO_CONF(so0),
        .READBACK(rb0), .MISMATCH(mm0)
    );

    conf_loader #(.CONF_WIDTH(8), .CLK_DIV(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(start1), .CONF_DATA(data1),
        .BUSY(busy1), .DONE(done1), .DEF_CONF(def1), .CLK_CONF(clkc1),
        .LD_CONF(ld1), .SI_CONF(si1), .SO_CONF(so1),
        .READBACK(rb1), .MISMATCH(mm1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) noise <= 8'($urandom);

    // Behavioural 8-bit target chains: only the first 8 rising shift clocks
    // after a load strobe land in the chain (the GAP clock is not captured).
    always @(posedge clkc0 or posedge RST or posedge corrupt or posedge ld0) begin
        if (RST) begin
            chain0 <= 8'h00;
            cnt0   <= 0;
        end else if (corrupt) begin
            chain0 <= 8'h3D;
        end else if (ld0) begin
            cnt0 <= 0;
        end else if (cnt0 < 8) begin
            chain0 <= {si0, chain0[7:1]};
            cnt0   <= cnt0 + 1;
        end
    end

    always @(posedge clkc1 or posedge RST or posedge ld1) begin
        if (RST) begin
            chain1 <= 8'h00;
            cnt1   <= 0;
        end else if (ld1) begin
            cnt1 <= 0;
        end else if (cnt1 < 8) begin
            chain1 <= {si1, chain1[7:1]};
            cnt1   <= cnt1 + 1;
        end
    end

`ifdef CONF_READBACK_EN
    assign so0 = chain0[0];
    assign so1 = chain1[0];
`else
    assign so0 = noise[0];
    assign so1 = noise[1];
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic busy;
        logic done;
        logic clk;
        logic ld;
        logic si;
    } outs_t;

    // Timeline of a load, k edges after the accepting edge: 8 bit periods,
    // one gap period, one load period, then a single DONE cycle.
    function automatic outs_t model_outs(input bit act, input int k, input logic [7:0] w, input int d);
        outs_t o;
        int    p;
        p = 2 * d;
        o = '0;
        if (act && k <= 10 * p) begin
            o.busy = 1'b1;
            if (k < 8 * p) begin
                o.clk = ((k % p) >= d);
                o.si  = w[k / p];
            end else if (k < 9 * p) begin
                o.clk = ((k % p) >= d);
            end else if (k < 10 * p) begin
                o.ld = 1'b1;
            end else begin
                o.done = 1'b1;
            end
        end
        return o;
    endfunction

    int         ecnt;
    bit         act0, act1, hp0, hp1;
    int         a0, a1;
    logic [7:0] w0, w1, snap0, snap1, pw0, pw1;
    logic       def0e, def1e, mm0e, mm1e;
    logic [7:0] rb0e, rb1e;

    initial begin
        outs_t e0, e1;
        ecnt = 0;
        act0 = 0; act1 = 0; hp0 = 0; hp1 = 0;
        a0 = 0; a1 = 0;
        w0 = 0; w1 = 0; snap0 = 0; snap1 = 0; pw0 = 0; pw1 = 0;
        def0e = 1; def1e = 1; mm0e = 0; mm1e = 0; rb0e = 0; rb1e = 0;
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                act0 = 0; act1 = 0; hp0 = 0; hp1 = 0;
                def0e = 1; def1e = 1; mm0e = 0; mm1e = 0; rb0e = 0; rb1e = 0;
            end else begin
                ecnt++;
                if (start0 && (!act0 || (ecnt - a0) >= 42)) begin
                    act0 = 1; a0 = ecnt; w0 = data0; snap0 = chain0;
                end
                if (start1 && (!act1 || (ecnt - a1) >= 22)) begin
                    act1 = 1; a1 = ecnt; w1 = data1; snap1 = chain1;
                end
                if (act0 && (ecnt - a0) == 40) begin
                    def0e = 0;
`ifdef CONF_READBACK_EN
                    rb0e = snap0; mm0e = hp0 && (snap0 != pw0); pw0 = w0; hp0 = 1;
`endif
                end
                if (act1 && (ecnt - a1) == 20) begin
                    def1e = 0;
`ifdef CONF_READBACK_EN
                    rb1e = snap1; mm1e = hp1 && (snap1 != pw1); pw1 = w1; hp1 = 1;
`endif
                end
                e0 = model_outs(act0, ecnt - a0, w0, 2);
                e1 = model_outs(act1, ecnt - a1, w1, 1);
                #1;
                chk("busy0", busy0, e0.busy);
                chk("done0", done0, e0.done);
                chk("clk_conf0", clkc0, e0.clk);
                chk("ld_conf0", ld0, e0.ld);
                chk("si_conf0", si0, e0.si);
                chk("def_conf0", def0, def0e);
                chk("readback0", rb0, rb0e);
                chk("mismatch0", mm0, mm0e);
                chk("busy1", busy1, e1.busy);
                chk("done1", done1, e1.done);
                chk("clk_conf1", clkc1, e1.clk);
                chk("ld_conf1", ld1, e1.ld);
                chk("si_conf1", si1, e1.si);
                chk("def_conf1", def1, def1e);
                chk("readback1", rb1, rb1e);
                chk("mismatch1", mm1, mm1e);
            end
        end
    end

    task automatic load0(input logic [7:0] w, input bit hold, output int lat,
                         output logic [7:0] sis, output int ldc,
                         output logic d_first, output logic d_last);
        @(negedge CLK);
        start0 = 1'b1;
        data0  = w;
        @(posedge CLK);
        #1;
        if (!hold) start0 = 1'b0;
        lat = -1; ldc = 0; sis = '0; d_first = def0; d_last = def0;
        for (int k = 0; k < 200; k++) begin
            if (k < 32 && (k % 4) == 1) sis[k / 4] = si0;
            if (ld0) ldc++;
            if (done0) begin
                lat = k;
                d_last = def0;
                break;
            end
            @(posedge CLK);
            #1;
        end
        start0 = 1'b0;
        $display("load0 word=%02h latency=%0d si=%02h ld_cycles=%0d def=%0b->%0b readback=%02h mismatch=%0b",
                 w, lat, sis, ldc, d_first, d_last, rb0, mm0);
    endtask

    task automatic load1(input logic [7:0] w, output int lat, output logic [15:0] cpat,
                         output logic [7:0] sis);
        @(negedge CLK);
        start1 = 1'b1;
        data1  = w;
        @(posedge CLK);
        #1;
        start1 = 1'b0;
        lat = -1; cpat = '0; sis = '0;
        for (int k = 0; k < 100; k++) begin
            if (k < 16) cpat[k] = clkc1;
            if (k < 16 && (k % 2) == 1) sis[k / 2] = si1;
            if (done1) begin
                lat = k;
                break;
            end
            @(posedge CLK);
            #1;
        end
        $display("load1 word=%02h latency=%0d clk_pattern=%04h si=%02h", w, lat, cpat, sis);
    endtask

    initial begin
        int         lat, ldc, ldseen, doneseen;
        logic [7:0] sis;
        logic [15:0] cpat;
        logic       d_first, d_last;

        RST = 1'b1; corrupt = 1'b0;
        start0 = 1'b0; data0 = '0; start1 = 1'b0; data1 = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_def", def0, 1'b1);
        chk("rst_clk", clkc0, 1'b0);
        chk("rst_ld", ld0, 1'b0);
        chk("rst_si", si0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_def1", def1, 1'b1);
        $display("reset busy=%0b def=%0b", busy0, def0);

        load0(8'hA5, 1'b0, lat, sis, ldc, d_first, d_last);
        chk("a5_latency", lat, 40);
        chk("a5_si_seq", sis, 8'hA5);
        chk("a5_ld_cycles", ldc, 4);
        chk("a5_def_before", d_first, 1'b1);
        chk("a5_def_after", d_last, 1'b0);

        // START held through the whole sequence, then back-to-back reload.
        @(posedge CLK);
        load0(8'h5A, 1'b1, lat, sis, ldc, d_first, d_last);
        chk("hold_latency", lat, 40);
        chk("hold_si_seq", sis, 8'h5A);
        @(posedge CLK);
        load0(8'h96, 1'b0, lat, sis, ldc, d_first, d_last);
        chk("b2b_latency", lat, 40);
        chk("b2b_si_seq", sis, 8'h96);
        chk("b2b_ld_cycles", ldc, 4);

        // Reset in bit period 3 aborts without a load strobe.
        @(posedge CLK);
        @(negedge CLK);
        start0 = 1'b1; data0 = 8'hFF;
        @(posedge CLK);
        #1;
        start0 = 1'b0;
        repeat (12) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_clk", clkc0, 1'b0);
        chk("abort_si", si0, 1'b0);
        chk("abort_ld", ld0, 1'b0);
        chk("abort_done", done0, 1'b0);
        chk("abort_def", def0, 1'b1);
        $display("abort busy=%0b def=%0b", busy0, def0);
        @(negedge CLK);
        RST = 1'b0;
        ldseen = 0; doneseen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK);
            #1;
            if (ld0) ldseen++;
            if (done0) doneseen++;
        end
        chk("abort_no_ld", ldseen, 0);
        chk("abort_no_done", doneseen, 0);
        chk("abort_def_hold", def0, 1'b1);

        load0(8'h3C, 1'b0, lat, sis, ldc, d_first, d_last);
        chk("rb1_readback", rb0, 8'h00);
        chk("rb1_mismatch", mm0, 1'b0);
        @(posedge CLK);
        load0(8'hC3, 1'b0, lat, sis, ldc, d_first, d_last);
`ifdef CONF_READBACK_EN
        chk("rb2_readback", rb0, 8'h3C);
`else
        chk("rb2_readback", rb0, 8'h00);
`endif
        chk("rb2_mismatch", mm0, 1'b0);
        @(negedge CLK);
        corrupt = 1'b1;
        #1;
        corrupt = 1'b0;
        load0(8'hC3, 1'b0, lat, sis, ldc, d_first, d_last);
`ifdef CONF_READBACK_EN
        chk("rb3_readback", rb0, 8'h3D);
        chk("rb3_mismatch", mm0, 1'b1);
`else
        chk("rb3_readback", rb0, 8'h00);
        chk("rb3_mismatch", mm0, 1'b0);
`endif

        @(posedge CLK);
        load1(8'hFF, lat, cpat, sis);
        chk("div1_latency", lat, 20);
        chk("div1_clk_pattern", cpat, 16'hAAAA);
        chk("div1_si_seq", sis, 8'hFF);

        repeat (5) @(posedge CLK);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
